// File: rtl/spi_flash_responder.sv
// spi_flash_responder: single-bit SPI flash target (mode 0) backed by a
// byte-wide valid/ready memory port; serves READ (0x03) with prefetch.
module spi_flash_responder #(
   parameter int ADDR_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 spi_csb,
   input  logic                 spi_clk,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic                 mem_valid,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic                 mem_ready,
   input  logic [7:0]           mem_rdata,
   output logic                 busy,
   output logic                 underrun,
   input  logic                 underrun_clr
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] csb_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_q;

   logic                   csb_s;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   rise;
   logic                   fall;
   logic                   mem_fire;
   logic [7:0]             cmd_next;
   logic [23:0]            addr_next;

   state_t                 state;
   logic [4:0]             bit_cnt;
   logic [7:0]             cmd_sr;
   logic [23:0]            addr_sr;
   logic [ADDR_BITS-1:0]   next_addr;
   logic [7:0]             shift_sr;
   logic [7:0]             pf_data;
   logic                   pf_valid;
   logic                   first;
   logic                   armed;
   logic                   discard;

   assign csb_s     = csb_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign rise      = sclk_s & ~sclk_q;
   assign fall      = ~sclk_s & sclk_q;
   assign mem_fire  = mem_valid & mem_ready;
   assign cmd_next  = {cmd_sr[6:0], mosi_s};
   assign addr_next = {addr_sr[22:0], mosi_s};

   // Bring the SPI pins into the clk domain; csb idles deasserted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csb_sync  <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         sclk_q    <= 1'b0;
      end else begin
         csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_q    <= sclk_s;
      end
   end

   // Protocol FSM, memory requester, data shifter and status flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         cmd_sr      <= '0;
         addr_sr     <= '0;
         next_addr   <= '0;
         shift_sr    <= '0;
         pf_data     <= '0;
         pf_valid    <= 1'b0;
         first       <= 1'b0;
         armed       <= 1'b0;
         discard     <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         mem_valid   <= 1'b0;
         mem_addr    <= '0;
         busy        <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         // a later set of underrun in this block overrides the clear
         if (underrun_clr) begin
            underrun <= 1'b0;
         end

         // completed read: drop it, load it directly, or park it
         if (mem_fire) begin
            mem_valid <= 1'b0;
            if (discard) begin
               discard <= 1'b0;
            end else if (first) begin
               shift_sr <= mem_rdata;
               spi_miso <= mem_rdata[7];
               first    <= 1'b0;
            end else begin
               pf_data  <= mem_rdata;
               pf_valid <= 1'b1;
            end
         end

         // keep one byte in flight whenever the prefetch slot is free
         if (state == DATA && !csb_s && !mem_valid &&
             !pf_valid && !discard) begin
            mem_valid <= 1'b1;
            mem_addr  <= next_addr;
            next_addr <= next_addr + ADDR_BITS'(1);
         end

         if (csb_s && state != IDLE) begin
            state       <= IDLE;
            busy        <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            pf_valid    <= 1'b0;
            first       <= 1'b0;
            armed       <= 1'b0;
            if (mem_valid && !mem_ready) begin
               discard <= 1'b1;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  if (!csb_s) begin
                     state   <= CMD;
                     bit_cnt <= '0;
                     busy    <= 1'b1;
                  end
               end
               CMD: begin
                  if (rise) begin
                     cmd_sr  <= cmd_next;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        unique case (cmd_next)
                           8'h03:        state <= ADDR;
                           8'hAB, 8'hFF: state <= IGNORE;
                           default:      state <= IGNORE;
                        endcase
                     end
                  end
               end
               ADDR: begin
                  if (rise) begin
                     addr_sr <= addr_next;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt     <= '0;
                        next_addr   <= addr_next[ADDR_BITS-1:0];
                        state       <= DATA;
                        spi_miso_oe <= 1'b1;
                        spi_miso    <= 1'b0;
                        shift_sr    <= '0;
                        first       <= 1'b1;
                        armed       <= 1'b0;
                     end
                  end
               end
               DATA: begin
                  if (rise) begin
                     armed <= 1'b1;
                     // first byte missed its slot: it goes out as zeros
                     if (first && !mem_fire) begin
                        first    <= 1'b0;
                        underrun <= 1'b1;
                     end
                  end else if (fall && armed) begin
                     armed   <= 1'b0;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        if (pf_valid) begin
                           shift_sr <= pf_data;
                           spi_miso <= pf_data[7];
                           pf_valid <= 1'b0;
                        end else begin
                           shift_sr <= '0;
                           spi_miso <= 1'b0;
                           underrun <= 1'b1;
                        end
                     end else begin
                        shift_sr <= {shift_sr[6:0], 1'b0};
                        spi_miso <= shift_sr[6];
                     end
                  end
               end
               IGNORE: begin
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable single-bit SPI flash target: the responder end of the SoC's flash interface.
- Lets an FPGA-side memory (BRAM or test ROM) stand in for the external QSPI flash, for loopback tests and simulation of the SoC boot path.
- Oversamples SPI pins on the system clock.
- Decodes READ (0x03), release-power-down (0xAB) and reset (0xFF), and serves data bytes through a valid/ready memory port.

Parameters:
- ADDR_BITS, 24, width of the flash byte address; the address wraps modulo 2^ADDR_BITS.
- SYNC_STAGES, 2, synchronizer depth on spi_csb, spi_clk and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock; must be ≥ 8× spi_clk frequency.
- resetn  in  1  asynchronous, active-low reset.
- spi_csb  in  1  chip select from the initiator, active low.
- spi_clk  in  1  SPI clock, mode 0.
- spi_mosi  in  1  initiator-to-target data (IO0).
- spi_miso  out  1  target-to-initiator data (IO1).
- spi_miso_oe  out  1  output enable for the IO1 pad driver.
- mem_valid  out  1  byte read request.
- mem_addr  out  ADDR_BITS  requested byte address.
- mem_ready  in  1  request accepted; mem_rdata is valid this cycle.
- mem_rdata  in  8  read byte.
- busy  out  1  high while spi_csb (synchronized) is low.
- underrun  out  1  sticky: a data byte was needed before memory returned it.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (resetn low, asynchronous) drives every output and state register to its reset value:
  - spi_miso=0, spi_miso_oe=0, mem_valid=0, mem_addr=0, busy=0, underrun=0.
  - FSM enters IDLE; both data buffers are emptied.
- Synchronization and edge detection:
  - spi_csb, spi_clk and spi_mosi each pass through SYNC_STAGES flops.
  - A rising edge on synchronized spi_clk is "rise"; a falling edge is "fall".
  - spi_mosi is sampled on rise.
  - spi_miso updates on fall, or on the first data-phase load described below.
- Bit order: MSB first everywhere (command, address, data).
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: on synchronized csb falling → CMD, bit counter = 0, busy=1.
  - CMD: shift 8 bits on rise. On the 8th bit:
    - 0x03 → ADDR.
    - 0xAB → IGNORE.
    - 0xFF → IGNORE.
    - any other value → IGNORE. MISO is never enabled in IGNORE.
  - ADDR: shift 24 bits.
    - The low ADDR_BITS bits form the start address; upper bits are discarded.
    - The clk cycle after the 24th rise: issue mem_valid with that address, then → DATA.
  - DATA:
    - spi_miso_oe=1.
    - On each fall, shift the next bit out of the 8-bit shift register.
    - After the 8th bit of a byte, load the shift register from the prefetch buffer.
    - If the prefetch buffer is empty at load time: load 0x00 and set underrun.
    - Whenever the prefetch buffer is empty and no request is outstanding, request the next address (previous + 1, wrapping 2^ADDR_BITS−1 → 0).
    - The first byte is loaded into the shift register directly; its MSB drives spi_miso before the first data fall.
- Memory handshake:
  - Once mem_valid is raised, it stays high and mem_addr stays stable until mem_ready.
  - The transfer completes on the cycle where mem_valid && mem_ready.
  - mem_rdata is captured that cycle.
  - At most one request is outstanding at a time.
- Chip-select deassert (synchronized csb high) in any state:
  - Next cycle: → IDLE, spi_miso_oe=0, spi_miso=0, busy=0, buffers cleared.
  - An outstanding mem request keeps mem_valid high until mem_ready; the returned byte is discarded.
  - A new transaction may start while that discard is pending. Its first request waits until the discard completes.
- spi_clk edges seen while csb is high are ignored.
- Partial bytes at deassert are dropped.
- underrun:
  - Set and clear in the same cycle: set wins.
  - underrun_clr has no other effect.

Test Plan:
- Basic read: memory returns mem_rdata = addr[7:0] with 1-cycle ready; send 0x03, 0x05 0x00 0x10, then clock 32 bits → MISO yields 0x10 0x11 0x12 0x13; mem_addr sequence 0x050010..0x050014; underrun=0.
- Wrap: READ at 0xFFFFFE, 3 bytes → data 0xFE 0xFF 0x00; mem_addr wraps 0xFFFFFF → 0x000000.
- Unsupported command: send 0x9F plus 24 clocks → spi_miso_oe stays 0, mem_valid never asserts, busy follows csb.
- Abort: csb high after 12 address bits, then a full READ at 0x000020 → first byte 0x20, no stale data.
- Slow memory: mem_ready delayed 40 clk cycles with spi_clk = clk/8 → the affected byte reads 0x00 and underrun=1; underrun_clr pulse → 0.
- Asynchronous reset mid-DATA: assert resetn low between clk edges → all outputs immediately at reset values; after release, a new READ at 0x000000 returns 0x00 0x01.
